// File: rtl/sprite_rom_fetch_if.sv
// sprite_rom_fetch_if
// Bundles the per-channel request handshake, the ROM read port and the pixel
// output of sprite_rom_fetch. All buses are flat vectors. Channel c occupies
// slice [c*W +: W] of each vector.
//
// Optional feature macro: SPRITE_FLIP_EN adds req_flip (per-channel lane mirror).
//
// Signals
//   req_valid [NCH]          request strobe per channel
//   req_addr  [NCH*ADDR_W]   base byte address per channel
//   req_flip  [NCH]          horizontal mirror, sampled at accept (SPRITE_FLIP_EN only)
//   req_ready [NCH]          channel idle
//   rom_addr  [NCH*ADDR_W]   registered ROM address per channel
//   rom_data  [NCH*ROM_DW]   ROM read data per channel
//   out_valid [NCH]          one-cycle completion pulse
//   out_data  [NCH*PIX_W]    assembled pixel, held until the next completion
// Modports
//   slave  : the fetcher
//   master : the requester together with the ROMs
interface sprite_rom_fetch_if #(
  parameter int NCH    = 3,
  parameter int ADDR_W = 11,
  parameter int ROM_DW = 8,
  parameter int PIX_W  = 16
);
  logic [NCH-1:0]        req_valid;
  logic [NCH*ADDR_W-1:0] req_addr;
  logic [NCH-1:0]        req_ready;
`ifdef SPRITE_FLIP_EN
  logic [NCH-1:0]        req_flip;
`endif
  logic [NCH*ADDR_W-1:0] rom_addr;
  logic [NCH*ROM_DW-1:0] rom_data;
  logic [NCH-1:0]        out_valid;
  logic [NCH*PIX_W-1:0]  out_data;

`ifdef SPRITE_FLIP_EN
  modport slave (
    input  req_valid, req_addr, req_flip, rom_data,
    output req_ready, rom_addr, out_valid, out_data
  );
  modport master (
    output req_valid, req_addr, req_flip, rom_data,
    input  req_ready, rom_addr, out_valid, out_data
  );
`else
  modport slave (
    input  req_valid, req_addr, rom_data,
    output req_ready, rom_addr, out_valid, out_data
  );
  modport master (
    output req_valid, req_addr, rom_data,
    input  req_ready, rom_addr, out_valid, out_data
  );
`endif
endinterface

// File: rtl/sprite_rom_fetch.sv
// sprite_rom_fetch
// N-channel sprite pixel fetcher. Each channel reads RATIO = PIX_W/ROM_DW
// consecutive bytes from its own narrow ROM and presents them as one PIX_W
// pixel. Lowest address goes to the least significant lane.
//
// Optional feature macro: SPRITE_FLIP_EN (per-channel byte-lane mirror).
//
// Ports
//   clk          system clock, posedge
//   rst_n        asynchronous active-low reset
//   bus          sprite_rom_fetch_if.slave (request / ROM / pixel buses)
//   o_dbg_state  per-channel FSM state, 2 bits per channel
//
// Handshake: a request on channel c is taken on a rising edge where
// req_valid[c] && req_ready[c]. req_ready[c] is high only while the channel
// is idle. A request seen while busy is simply dropped; nothing is queued.
// out_valid[c] pulses for one cycle on the edge that loads the new pixel.
//
// Timing, relative to the accept edge E0:
//   Ek (k=0..RATIO-1)       rom_addr <= base + k (modulo 2^ADDR_W)
//   E(k+ROM_LAT)            byte k sampled from rom_data
//   E(RATIO+ROM_LAT-1)      out_data/out_valid updated, channel idle again
module sprite_rom_fetch #(
  parameter int NCH     = 3,
  parameter int ADDR_W  = 11,
  parameter int ROM_DW  = 8,
  parameter int PIX_W   = 16,
  parameter int ROM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sprite_rom_fetch_if.slave    bus,
  output logic [2*NCH-1:0]     o_dbg_state
);
  localparam int RATIO = PIX_W / ROM_DW;
  localparam int LAST  = RATIO + ROM_LAT - 1;     // edge index of completion
  localparam int CW    = $clog2(LAST + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,   // addresses still being issued
    S_DRAIN = 2'd2    // waiting on the last ROM_LAT bytes
  } state_t;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t              r_state;
    logic [CW-1:0]       r_cnt;       // edges elapsed since accept
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [PIX_W-1:0]    r_shadow;    // partial pixel, never visible
    logic [PIX_W-1:0]    r_out_data;
    logic                r_out_valid;
    logic                r_flip;

    logic                w_accept;
    logic                w_issue;
    logic                w_capture;
    logic                w_last;
    logic                w_flip_in;
    logic [CW-1:0]       w_idx;
    logic [CW-1:0]       w_lane;
    logic [ROM_DW-1:0]   w_byte;
    logic [PIX_W-1:0]    w_word;

`ifdef SPRITE_FLIP_EN
    assign w_flip_in = bus.req_flip[c];
`else
    assign w_flip_in = 1'b0;
`endif

    assign w_byte    = bus.rom_data[c*ROM_DW +: ROM_DW];
    assign w_accept  = bus.req_valid[c] && (r_state == S_IDLE);
    // r_cnt starts at 1 after accept, so with RATIO=1 nothing further is issued.
    assign w_issue   = (r_state == S_FETCH) && (r_cnt <= CW'(RATIO - 1));
    assign w_capture = (r_state != S_IDLE) && (r_cnt >= CW'(ROM_LAT));
    assign w_last    = (r_state != S_IDLE) && (r_cnt == CW'(LAST));
    assign w_idx     = r_cnt - CW'(ROM_LAT);
    assign w_lane    = r_flip ? (CW'(RATIO - 1) - w_idx) : w_idx;

    // Shadow with the byte arriving this cycle merged into its lane.
    always_comb begin
      w_word = r_shadow;
      w_word[w_lane*ROM_DW +: ROM_DW] = w_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        r_base      <= '0;
        r_rom_addr  <= '0;
        r_shadow    <= '0;
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
        r_flip      <= 1'b0;
      end else begin
        r_out_valid <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_state    <= S_FETCH;
              r_cnt      <= CW'(1);
              r_base     <= bus.req_addr[c*ADDR_W +: ADDR_W];
              r_rom_addr <= bus.req_addr[c*ADDR_W +: ADDR_W];
              r_shadow   <= '0;
              r_flip     <= w_flip_in;
            end
          end
          default: begin
            if (w_issue) r_rom_addr <= r_base + ADDR_W'(r_cnt);
            if (w_last) begin
              r_out_data  <= w_word;
              r_out_valid <= 1'b1;
              r_state     <= S_IDLE;
              r_cnt       <= '0;
            end else begin
              if (w_capture) r_shadow <= w_word;
              r_cnt <= r_cnt + CW'(1);
              // Last address goes out at E(RATIO-1); from then on only data remains.
              if ((r_state == S_FETCH) && (r_cnt >= CW'(RATIO - 1))) r_state <= S_DRAIN;
            end
          end
        endcase
      end
    end

    assign bus.req_ready[c]                   = (r_state == S_IDLE);
    assign bus.rom_addr[c*ADDR_W +: ADDR_W]   = r_rom_addr;
    assign bus.out_valid[c]                   = r_out_valid;
    assign bus.out_data[c*PIX_W +: PIX_W]     = r_out_data;
    assign o_dbg_state[c*2 +: 2]              = r_state;
  end
endmodule

// File: tb/tb_sprite_rom_fetch.sv
module tb_sprite_rom_fetch;
  localparam int NCH    = 3;
  localparam int AW     = 11;
  localparam int DW     = 8;
  localparam int PW     = 16;
  localparam int LAT    = 1;
  localparam int RATIO  = PW / DW;
  localparam int LEDGE  = RATIO + LAT - 1;
  localparam int PWB    = 32;
  localparam int LATB   = 2;
`ifdef SPRITE_FLIP_EN
  localparam bit FLIP_ON = 1'b1;
`else
  localparam bit FLIP_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sprite_rom_fetch_if #(.NCH(NCH), .ADDR_W(AW), .ROM_DW(DW), .PIX_W(PW))  bus_a ();
  sprite_rom_fetch_if #(.NCH(1),   .ADDR_W(AW), .ROM_DW(DW), .PIX_W(PWB)) bus_b ();
  logic [2*NCH-1:0] dbg_a;
  logic [1:0]       dbg_b;

  sprite_rom_fetch #(.NCH(NCH), .ADDR_W(AW), .ROM_DW(DW), .PIX_W(PW), .ROM_LAT(LAT)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .o_dbg_state(dbg_a));
  sprite_rom_fetch #(.NCH(1), .ADDR_W(AW), .ROM_DW(DW), .PIX_W(PWB), .ROM_LAT(LATB)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .o_dbg_state(dbg_b));

  // ---------------- ROM models ----------------
  logic [DW-1:0] mem   [NCH][2048];
  logic [DW-1:0] mem_b [2048];

  // ROM_LAT=1: data follows the registered address within the cycle.
  always_comb begin
    bus_a.rom_data = '0;
    for (int c = 0; c < NCH; c++)
      bus_a.rom_data[c*DW +: DW] = mem[c][bus_a.rom_addr[c*AW +: AW]];
  end
  // ROM_LAT=2: one extra register stage.
  always @(posedge clk) bus_b.rom_data <= mem_b[bus_b.rom_addr];

  // ---------------- scoreboard / counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model for dut_a: timing from accept edge, words from ROM contents.
  int            cyc;
  int            due     [NCH];   // edge number of the completion pulse, -1 if none
  int            acc     [NCH];   // edge number of the last accept
  bit            started [NCH];
  logic [AW-1:0] m_base  [NCH];
  logic [PW-1:0] held    [NCH];
  logic [PW-1:0] exp_q   [NCH][$];

  function automatic logic [PW-1:0] ref_word(input int c, input logic [AW-1:0] a, input bit flip);
    logic [PW-1:0] w;
    logic [AW-1:0] ak;
    int lane;
    w = '0;
    for (int k = 0; k < RATIO; k++) begin
      ak = a + AW'(k);
      lane = flip ? (RATIO - 1 - k) : k;
      w[lane*DW +: DW] = mem[c][ak];
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      due[c] = -1;
      acc[c] = 0;
      started[c] = 1'b0;
      m_base[c] = '0;
      held[c] = '0;
      exp_q[c].delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Called at a negedge; cyc = posedges elapsed.
  task automatic check_a();
    bit ev;
    int k;
    logic [AW-1:0] ea;
    for (int c = 0; c < NCH; c++) begin
      ev = (cyc == due[c]);
      chk($sformatf("ready ch%0d cyc%0d", c, cyc), 64'(bus_a.req_ready[c]), 64'(cyc >= due[c]));
      chk($sformatf("out_valid ch%0d cyc%0d", c, cyc), 64'(bus_a.out_valid[c]), 64'(ev));
      if (ev && exp_q[c].size() > 0) held[c] = exp_q[c].pop_front();
      chk($sformatf("out_data ch%0d cyc%0d", c, cyc), 64'(bus_a.out_data[c*PW +: PW]), 64'(held[c]));
      if (started[c]) begin
        k = cyc - acc[c];
        if (k > RATIO - 1) k = RATIO - 1;
        ea = m_base[c] + AW'(k);
      end else begin
        ea = '0;
      end
      chk($sformatf("rom_addr ch%0d cyc%0d", c, cyc), 64'(bus_a.rom_addr[c*AW +: AW]), 64'(ea));
    end
  endtask

  // Driver: one clock cycle of stimulus on dut_a with model bookkeeping.
  task automatic cycle_a(input logic [NCH-1:0] v, input logic [NCH*AW-1:0] a, input logic [NCH-1:0] f);
    bus_a.req_valid = v;
    bus_a.req_addr  = a;
`ifdef SPRITE_FLIP_EN
    bus_a.req_flip  = f;
`endif
    @(negedge clk);
    check_a();
    for (int c = 0; c < NCH; c++) begin
      if (v[c] && (cyc >= due[c])) begin
        acc[c]     = cyc + 1;
        due[c]     = cyc + 1 + LEDGE;
        m_base[c]  = a[c*AW +: AW];
        started[c] = 1'b1;
        exp_q[c].push_back(ref_word(c, a[c*AW +: AW], FLIP_ON && f[c]));
      end
    end
    tick();
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) cycle_a('0, '0, '0);
  endtask

  // Directed run on dut_b (PIX_W=32, ROM_LAT=2): expect 4 addresses and a pulse 5 edges after accept.
  task automatic run_b(input logic [AW-1:0] a, input bit f, input logic [PWB-1:0] expw);
    logic [AW-1:0] ea;
    int k;
    bus_b.req_valid = 1'b1;
    bus_b.req_addr  = a;
`ifdef SPRITE_FLIP_EN
    bus_b.req_flip  = f;
`endif
    @(negedge clk);
    chk("b ready before", 64'(bus_b.req_ready), 64'(1));
    tick();
    bus_b.req_valid = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      k = (e > 3) ? 3 : e;
      ea = a + AW'(k);
      chk($sformatf("b rom_addr e%0d", e), 64'(bus_b.rom_addr), 64'(ea));
      chk($sformatf("b out_valid e%0d", e), 64'(bus_b.out_valid), 64'(e == 5));
      if (e == 1) chk("b ready busy", 64'(bus_b.req_ready), 64'(0));
      if (e >= 5) chk($sformatf("b out_data e%0d", e), 64'(bus_b.out_data), 64'(expw));
    end
    if (f) k = 0;
  endtask

  // ---------------- table vectors (ROM[i]=i) ----------------
  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
    logic [PW-1:0] exp;
  } vec_t;
  vec_t vecs [6];

  initial begin
    logic [NCH*AW-1:0] av;
    logic [NCH-1:0]    vv;
    logic [NCH-1:0]    ff;

    vecs[0] = '{ch: 0, addr: 11'h010, exp: 16'h1110};
    vecs[1] = '{ch: 1, addr: 11'h7FF, exp: 16'h00FF};
    vecs[2] = '{ch: 2, addr: 11'h123, exp: 16'h2423};
    vecs[3] = '{ch: 0, addr: 11'h7FE, exp: 16'hFFFE};
    vecs[4] = '{ch: 1, addr: 11'h000, exp: 16'h0100};
    vecs[5] = '{ch: 2, addr: 11'h3FF, exp: 16'h00FF};

    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 2048; i++) mem[c][i] = DW'(i);
    for (int i = 0; i < 2048; i++) mem_b[i] = DW'(i);

    bus_a.req_valid = '0;
    bus_a.req_addr  = '0;
    bus_b.req_valid = '0;
    bus_b.req_addr  = '0;
`ifdef SPRITE_FLIP_EN
    bus_a.req_flip  = '0;
    bus_b.req_flip  = '0;
`endif
    model_reset();
    cyc = 0;

    // Reset state
    rst_n = 1'b0;
    bus_a.req_valid = '1;   // must be ignored while in reset
    #12;
    chk("reset out_valid", 64'(bus_a.out_valid), 64'(0));
    chk("reset out_data", 64'(bus_a.out_data), 64'(0));
    chk("reset rom_addr", 64'(bus_a.rom_addr), 64'(0));
    chk("reset req_ready", 64'(bus_a.req_ready), 64'(3'b111));
    chk("reset b out_data", 64'(bus_b.out_data), 64'(0));
    @(posedge clk);
    #1;
    chk("reset ignores req", 64'(bus_a.req_ready), 64'(3'b111));
    bus_a.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;

    // Table vectors, first one immediately after reset release
    for (int i = 0; i < 6; i++) begin
      av = '0;
      vv = '0;
      av[vecs[i].ch*AW +: AW] = vecs[i].addr;
      vv[vecs[i].ch] = 1'b1;
      cycle_a(vv, av, '0);
      idle_a(LEDGE + 1);
      chk($sformatf("table vec%0d", i), 64'(bus_a.out_data[vecs[i].ch*PW +: PW]), 64'(vecs[i].exp));
    end

    // Concurrency and busy requests
    av = '0;
    av[0*AW +: AW] = 11'h020;
    av[1*AW +: AW] = 11'h031;
    av[2*AW +: AW] = 11'h042;
    cycle_a(3'b111, av, '0);
    cycle_a(3'b111, '1, '0);         // busy: dropped
    idle_a(LEDGE + 1);
    chk("conc ch0", 64'(bus_a.out_data[0*PW +: PW]), 64'(16'h2120));
    chk("conc ch1", 64'(bus_a.out_data[1*PW +: PW]), 64'(16'h3231));
    chk("conc ch2", 64'(bus_a.out_data[2*PW +: PW]), 64'(16'h4342));

    // Reset one edge after accept: fetch aborted, out_data cleared
    av = '0;
    av[0*AW +: AW] = 11'h050;
    cycle_a(3'b001, av, '0);
    idle_a(1);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("midrst out_valid", 64'(bus_a.out_valid), 64'(0));
    chk("midrst out_data", 64'(bus_a.out_data), 64'(0));
    chk("midrst rom_addr", 64'(bus_a.rom_addr), 64'(0));
    chk("midrst ready", 64'(bus_a.req_ready), 64'(3'b111));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst no pulse %0d", i), 64'(bus_a.out_valid), 64'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    av = '0;
    av[0*AW +: AW] = 11'h0AB;
    cycle_a(3'b001, av, '0);
    idle_a(LEDGE + 1);
    chk("after midrst", 64'(bus_a.out_data[0*PW +: PW]), 64'(16'hACAB));

    // Randomized traffic against the model, distinct ROM contents per channel
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 2048; i++) mem[c][i] = DW'($urandom_range(0, 255));
    for (int n = 0; n < 400; n++) begin
      vv = NCH'($urandom_range(0, 7));
      ff = NCH'($urandom_range(0, 7));
      for (int c = 0; c < NCH; c++) av[c*AW +: AW] = AW'($urandom_range(0, 2047));
      cycle_a(vv, av, ff);
    end
    idle_a(LEDGE + 2);

    // Wider pixel, longer latency
    run_b(11'h004, 1'b0, 32'h07060504);
`ifdef SPRITE_FLIP_EN
    run_b(11'h004, 1'b1, 32'h04050607);
`endif
    run_b(11'h7FE, 1'b0, 32'h0100FFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
